// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational in fetch; resolved branches update the table on the next edge.
module branch_predictor #(
  parameter int IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [31:0] pc_f,
  output logic        pred_taken_f,
  output logic [31:0] pred_target_f,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 30 - IDX_BITS;

  localparam logic [1:0] CTR_WEAK_NT = 2'b01;
  localparam logic [1:0] CTR_WEAK_T  = 2'b10;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [IDX_BITS-1:0] f_idx, u_idx;
  logic [TAG_W-1:0]    f_tag, u_tag;
  logic                f_hit, u_hit;

  assign f_idx = pc_f[IDX_BITS+1:2];
  assign f_tag = pc_f[31:IDX_BITS+2];
  assign u_idx = upd_pc[IDX_BITS+1:2];
  assign u_tag = upd_pc[31:IDX_BITS+2];

  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // Reads the registered table only, so an update never bypasses into the same-cycle lookup.
  assign pred_taken_f  = f_hit & ctr_q[f_idx][1];
  assign pred_target_f = pred_taken_f ? target_q[f_idx] : pc_f + 32'd4;

  // NOTE: the table arrays sit on the async reset because a defined power-up image is
  // required; this prevents mapping them to RAM macros, which is acceptable at this size.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WEAK_NT;
      end
    end else if (clear) begin
      // Clear takes priority over a coincident update; tags and targets are left stale.
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_WEAK_NT;
      end
    end else if (upd_en) begin
      if (u_hit) begin
        if (upd_taken) begin
          target_q[u_idx] <= upd_target;
          if (ctr_q[u_idx] != 2'b11) ctr_q[u_idx] <= ctr_q[u_idx] + 2'd1;
        end else if (ctr_q[u_idx] != 2'b00) begin
          ctr_q[u_idx] <= ctr_q[u_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= upd_target;
        ctr_q[u_idx]    <= CTR_WEAK_T;
      end
    end
  end

  // Statistics counters saturate rather than wrap so long runs never read as small.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (upd_en) begin
      if (branch_cnt != 32'hFFFF_FFFF) branch_cnt <= branch_cnt + 32'd1;
      if (upd_mispredict && (mispred_cnt != 32'hFFFF_FFFF)) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor: the driver queues hand-computed
// expectations, a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  typedef struct {
    string       name;
    logic        taken;
    logic [31:0] target;
    logic [31:0] bcnt;
    logic [31:0] mcnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic look_v = 1'b0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  branch_predictor #(.IDX_BITS(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .clear          (clear),
    .pc_f           (pc_f),
    .pred_taken_f   (pred_taken_f),
    .pred_target_f  (pred_target_f),
    .upd_en         (upd_en),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_mispredict (upd_mispredict),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; the expectation describes outputs seen during that cycle.
  task automatic step(input string name, input logic [31:0] pc,
                      input logic ue, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utgt, input logic um, input logic clr,
                      input logic et, input logic [31:0] etgt,
                      input logic [31:0] eb, input logic [31:0] em);
    exp_t e;
    @(posedge clk);
    #1;
    pc_f           = pc;
    upd_en         = ue;
    upd_pc         = upc;
    upd_taken      = ut;
    upd_target     = utgt;
    upd_mispredict = um;
    clear          = clr;
    e.name   = name;
    e.taken  = et;
    e.target = etgt;
    e.bcnt   = eb;
    e.mcnt   = em;
    exp_q.push_back(e);
    look_v = 1'b1;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (look_v) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard: output seen with no expectation queued");
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, ".taken"},  {31'b0, pred_taken_f}, {31'b0, mon_e.taken});
        check({mon_e.name, ".target"}, pred_target_f, mon_e.target);
        check({mon_e.name, ".bcnt"},   branch_cnt,    mon_e.bcnt);
        check({mon_e.name, ".mcnt"},   mispred_cnt,   mon_e.mcnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; clear = 1'b0; pc_f = '0; upd_en = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;

    //   name        pc_f           ue    upd_pc      ut    upd_tgt        um    clr   e_tk  e_tgt          e_bcnt         e_mcnt
    step("in_reset", 32'h100,       1'b0, 32'h0,      1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h104,       32'd0,         32'd0);
    #2 reset = 1'b0;
    step("post_rst", 32'h100,       1'b0, 32'h0,      1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h104,       32'd0,         32'd0);
    step("alloc",    32'h100,       1'b1, 32'h100,    1'b1, 32'h200,       1'b1, 1'b0, 1'b0, 32'h104,       32'd0,         32'd0);
    step("hit_10",   32'h100,       1'b0, 32'h0,      1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h200,       32'd1,         32'd1);
    step("nt1",      32'h100,       1'b1, 32'h100,    1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h200,       32'd1,         32'd1);
    step("nt2",      32'h100,       1'b1, 32'h100,    1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h104,       32'd2,         32'd2);
    step("ctr00",    32'h100,       1'b0, 32'h0,      1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h104,       32'd3,         32'd2);
    step("tk1",      32'h100,       1'b1, 32'h100,    1'b1, 32'h200,       1'b1, 1'b0, 1'b0, 32'h104,       32'd3,         32'd2);
    step("tk2",      32'h100,       1'b1, 32'h100,    1'b1, 32'h200,       1'b1, 1'b0, 1'b0, 32'h104,       32'd4,         32'd3);
    step("tk3_tgt",  32'h100,       1'b1, 32'h100,    1'b1, 32'h220,       1'b1, 1'b0, 1'b1, 32'h200,       32'd5,         32'd4);
    step("tk_sat",   32'h100,       1'b1, 32'h100,    1'b1, 32'h220,       1'b0, 1'b0, 1'b1, 32'h220,       32'd6,         32'd5);
    step("nt_from11",32'h100,       1'b1, 32'h100,    1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h220,       32'd7,         32'd5);
    step("ctr10_mis0en", 32'h100,   1'b0, 32'h0,      1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h220,       32'd8,         32'd6);
    step("alias_alc",32'h140,       1'b1, 32'h140,    1'b1, 32'h300,       1'b1, 1'b0, 1'b0, 32'h144,       32'd8,         32'd6);
    step("alias_old",32'h100,       1'b0, 32'h0,      1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h104,       32'd9,         32'd7);
    step("alias_new",32'h140,       1'b1, 32'h100,    1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h300,       32'd9,         32'd7);
    step("miss_nt",  32'h140,       1'b0, 32'h0,      1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h300,       32'd10,        32'd7);
    step("idx1_miss",32'h104,       1'b1, 32'h106,    1'b1, 32'h400,       1'b1, 1'b0, 1'b0, 32'h108,       32'd10,        32'd7);
    step("low_bits", 32'h107,       1'b0, 32'h0,      1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h400,       32'd11,        32'd8);
    step("clr_upd",  32'h140,       1'b1, 32'h100,    1'b1, 32'h200,       1'b1, 1'b1, 1'b1, 32'h300,       32'd11,        32'd8);
    step("clr_100",  32'h100,       1'b0, 32'h0,      1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h104,       32'd12,        32'd9);
    step("clr_140",  32'h140,       1'b0, 32'h0,      1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h144,       32'd12,        32'd9);
    step("clr_107",  32'h107,       1'b0, 32'h0,      1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h10B,       32'd12,        32'd9);
    step("pc_wrap",  32'hFFFF_FFFC, 1'b0, 32'h0,      1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         32'd12,        32'd9);

    // Preload the statistics counters near their ceiling.
    @(posedge clk);
    #1 look_v = 1'b0;
    #2;
    force dut.branch_cnt  = 32'hFFFF_FFFF;
    force dut.mispred_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.branch_cnt;
    release dut.mispred_cnt;

    step("sat_a",    32'h100,       1'b1, 32'h200,    1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h104,       32'hFFFF_FFFF, 32'hFFFF_FFFE);
    step("sat_b",    32'h100,       1'b1, 32'h200,    1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h104,       32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step("sat_c",    32'h300,       1'b1, 32'h300,    1'b1, 32'h500,       1'b1, 1'b0, 1'b0, 32'h304,       32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Reset lands on the edge that would have applied the pending allocation.
    #5 reset = 1'b1;
    @(posedge clk);
    #1 look_v = 1'b0;
    upd_en = 1'b0;
    #1 reset = 1'b0;
    step("rst_drop", 32'h300,       1'b0, 32'h0,      1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h304,       32'd0,         32'd0);

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter IDX_BITS, default 4, giving log2 of the table entry count (16 entries).
REQ-002 SHALL have port clk, input, 1, the rising-edge clock.
REQ-003 SHALL have port reset, input, 1, an asynchronous active-high reset.
REQ-004 SHALL have port clear, input, 1, a synchronous invalidate of all table entries.
REQ-005 SHALL have port pc_f, input, 32, the fetch-stage PC being looked up.
REQ-006 SHALL have port pred_taken_f, output, 1, the prediction for pc_f, fed to IF/ID and then ID/EX as pred_takenD.
REQ-007 SHALL have port pred_target_f, output, 32, the predicted next PC, fed onward as pred_targetD.
REQ-008 SHALL have port upd_en, input, 1, a resolved branch from the EX stage (1-cycle pulse per branch).
REQ-009 SHALL have port upd_pc, input, 32, the PC of the resolved branch.
REQ-010 SHALL have port upd_taken, input, 1, the actual branch outcome.
REQ-011 SHALL have port upd_target, input, 32, the actual taken target.
REQ-012 SHALL have port upd_mispredict, input, 1, asserted with upd_en when the EX-stage comparison of the outcome against pred_takenE/pred_targetE failed.
REQ-013 SHALL have port branch_cnt, output, 32, the resolved-branch count.
REQ-014 SHALL have port mispred_cnt, output, 32, the mispredict count.

Function
REQ-015 SHALL hold 2^IDX_BITS entries, each containing valid (1 bit), tag (pc[31:2+IDX_BITS]), target (32 bits) and ctr (2-bit saturating counter).
REQ-016 SHALL derive the index as pc[IDX_BITS+1:2] and the tag as pc[31:IDX_BITS+2]; bits pc[1:0] are ignored.
REQ-017 SHALL define hit as: entry valid and stored tag equal to the pc_f tag.
REQ-018 SHALL make lookup combinational from registered table state, with 0-cycle latency.
REQ-019 SHALL drive pred_taken_f = hit AND ctr[1].
REQ-020 SHALL drive pred_target_f = stored target when pred_taken_f is 1, otherwise pc_f+4 (mod 2^32).
REQ-021 SHALL apply updates at the clk edge following upd_en=1; a lookup of the same index in the update cycle returns the pre-update contents (no bypass).
REQ-022 On an update miss (invalid or tag mismatch) with upd_taken=1, SHALL allocate the entry: valid=1, tag written, target=upd_target, ctr=2'b10, replacing any old entry.
REQ-023 On an update miss with upd_taken=0, SHALL leave the table unchanged.
REQ-024 On an update hit with upd_taken=1, SHALL increment ctr saturating at 2'b11 and write target=upd_target.
REQ-025 On an update hit with upd_taken=0, SHALL decrement ctr saturating at 2'b00 and leave target unchanged.
REQ-026 On upd_en=1, SHALL increment branch_cnt by 1, saturating at 32'hFFFF_FFFF.
REQ-027 On upd_en=1 with upd_mispredict=1, SHALL increment mispred_cnt by 1, saturating at 32'hFFFF_FFFF.
REQ-028 SHALL ignore upd_mispredict when upd_en=0.
REQ-029 On clear=1, SHALL set all valid bits to 0 and all ctr to 2'b01, leaving targets, tags and counters unchanged.
REQ-030 When clear=1 and upd_en=1 occur in the same cycle, clear SHALL win for table state (no allocation), while branch_cnt and mispred_cnt still update.

Reset
REQ-031 While reset=1, SHALL force all valid=0, ctr=2'b01, tag=0, target=0, branch_cnt=0 and mispred_cnt=0, asynchronously.
REQ-032 During and after reset, SHALL drive pred_taken_f=0 and pred_target_f=pc_f+4 until an allocation occurs.
REQ-033 Reset asserted mid-update SHALL discard that update.

Verification
REQ-034 Bench SHALL cover: after reset, pc_f=0x100 -> pred_taken_f=0, pred_target_f=0x104, both counters 0.
REQ-035 Bench SHALL cover: update pc=0x100 taken target 0x200 -> next cycle pc_f=0x100 gives pred_taken_f=1, pred_target_f=0x200, branch_cnt=1.
REQ-036 Bench SHALL cover: from ctr=10, two not-taken updates to 0x100 -> ctr=00, pred_taken_f=0; three taken updates -> ctr=11 (saturated), pred_taken_f=1.
REQ-037 Bench SHALL cover: alias 0x140 (same index, different tag) taken to 0x300 -> 0x100 lookup misses (pred_target_f=0x104), 0x140 lookup predicts 0x300.
REQ-038 Bench SHALL cover: same-cycle clear and taken update to 0x100 with upd_mispredict=1 -> entry invalid, branch_cnt and mispred_cnt both increment.
REQ-039 Bench SHALL cover: preloaded branch_cnt=0xFFFF_FFFF plus upd_en -> branch_cnt stays 0xFFFF_FFFF.
